// File: rtl/tc_pipe_mul_sat.sv
// -----------------------------------------------------------------------------
// tc_pipe_mul_sat
//   Pipelined signed multiplier with optional rounding right shift and an
//   overflow flag. A pair accepted with ce=1 and din_valid=1 produces its
//   result exactly NUM_STAGE enabled cycles later. With ce=0 every register,
//   valid bits included, holds its value.
//
//   Stage layout:
//     NUM_STAGE=1 : multiply, round and clip are combinational; only the
//                   output is registered.
//     NUM_STAGE=2 : operand registers, then the output register.
//     NUM_STAGE>=3: operand registers, product register, (NUM_STAGE-3)
//                   product retiming registers, then the output register.
//
//   Build option:
//     TC_PIPE_MUL_SAT_EN defined   -> an out-of-range result is clamped to
//                                     the nearest DOUT_WIDTH limit.
//     TC_PIPE_MUL_SAT_EN undefined -> the low DOUT_WIDTH bits are output.
//     ovf is computed the same way in both builds.
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst     in   synchronous active-high reset
//   ce         in   pipeline advance enable
//   din_valid  in   din0/din1 carry a valid pair
//   din0       in   signed operand A, DIN0_WIDTH bits
//   din1       in   signed operand B, DIN1_WIDTH bits
//   dout_valid out  dout/ovf carry a result
//   dout       out  signed result, DOUT_WIDTH bits
//   ovf        out  rounded product did not fit DOUT_WIDTH
// -----------------------------------------------------------------------------
module tc_pipe_mul_sat #(
  parameter int DIN0_WIDTH = 18,
  parameter int DIN1_WIDTH = 18,
  parameter int DOUT_WIDTH = 34,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ce,
  input  logic                         din_valid,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         dout_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic [PW:0] RND =
    (SHIFT > 0) ? ((PW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  // Product and its valid bit as seen by the output stage.
  logic signed [PW-1:0]         w_p_pre;
  logic                         w_vld_pre;

  logic signed [PW:0]           w_r;
  logic [PW-DOUT_WIDTH+1:0]     w_hi;
  logic                         w_ovf;
  logic signed [DOUT_WIDTH-1:0] w_dout;

  generate
    if (NUM_STAGE == 1) begin : g_n1
      assign w_p_pre   = PW'(din0) * PW'(din1);
      assign w_vld_pre = din_valid;
    end else begin : g_in
      logic signed [DIN0_WIDTH-1:0] r_a;
      logic signed [DIN1_WIDTH-1:0] r_b;
      logic                         r_vld_in;
      logic signed [PW-1:0]         w_p_in;

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          r_vld_in <= 1'b0;
          r_a      <= '0;
          r_b      <= '0;
        end else if (ce) begin
          r_vld_in <= din_valid;
          if (din_valid) begin
            r_a <= din0;
            r_b <= din1;
          end
        end
      end

      assign w_p_in = PW'(r_a) * PW'(r_b);

      if (NUM_STAGE == 2) begin : g_n2
        assign w_p_pre   = w_p_in;
        assign w_vld_pre = r_vld_in;
      end else begin : g_nx
        // r_p[2] is the product register; higher indices are pure delay.
        logic signed [PW-1:0]   r_p [2:NUM_STAGE-1];
        logic [NUM_STAGE-1:2]   r_pv;

        always_ff @(posedge ap_clk) begin
          if (ap_rst) begin
            r_pv <= '0;
            for (int k = 2; k < NUM_STAGE; k++) begin
              r_p[k] <= '0;
            end
          end else if (ce) begin
            r_pv[2] <= r_vld_in;
            if (r_vld_in) begin
              r_p[2] <= w_p_in;
            end
            for (int k = 3; k < NUM_STAGE; k++) begin
              r_pv[k] <= r_pv[k-1];
              if (r_pv[k-1]) begin
                r_p[k] <= r_p[k-1];
              end
            end
          end
        end

        assign w_p_pre   = r_p[NUM_STAGE-1];
        assign w_vld_pre = r_pv[NUM_STAGE-1];
      end
    end
  endgenerate

  // Round half toward +inf, then check whether the bits above the output
  // sign bit are a pure sign extension.
  always_comb begin
    w_r    = ($signed({w_p_pre[PW-1], w_p_pre}) + $signed(RND)) >>> SHIFT;
    w_hi   = w_r[PW:DOUT_WIDTH-1];
    w_ovf  = !((&w_hi) || !(|w_hi));
    w_dout = w_r[DOUT_WIDTH-1:0];
`ifdef TC_PIPE_MUL_SAT_EN
    if (w_ovf) begin
      w_dout = w_r[PW] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                       : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    end
`else
`endif
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      ovf        <= 1'b0;
    end else if (ce) begin
      dout_valid <= w_vld_pre;
      if (w_vld_pre) begin
        dout <= w_dout;
        ovf  <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_tc_pipe_mul_sat.sv
// -----------------------------------------------------------------------------
// tb_tc_pipe_mul_sat
//   Four configurations of tc_pipe_mul_sat share one stimulus stream. A
//   reference model keeps the history of enabled cycles since the last reset
//   and predicts each output from plain integer arithmetic.
//     u0: 18x18 -> 34, 3 stages, no shift (defaults)
//     u1:  8x8  -> 10, 2 stages, shift 4
//     u2: 18x18 -> 34, 1 stage,  no shift
//     u3: 12x10 -> 12, 5 stages, shift 3
// -----------------------------------------------------------------------------
module tb_tc_pipe_mul_sat;

  localparam int NI = 4;
  localparam int P_W0 [NI] = '{18,  8, 18, 12};
  localparam int P_W1 [NI] = '{18,  8, 18, 10};
  localparam int P_DW [NI] = '{34, 10, 34, 12};
  localparam int P_NS [NI] = '{ 3,  2,  1,  5};
  localparam int P_SH [NI] = '{ 0,  4,  0,  3};

  logic        clk;
  logic        ap_rst;
  logic        ce;
  logic        din_valid;
  logic [17:0] din0;
  logic [17:0] din1;

  logic [NI-1:0] vld;
  logic [NI-1:0] ovf;
  logic [33:0]   dout0;
  logic [9:0]    dout1;
  logic [33:0]   dout2;
  logic [11:0]   dout3;
  longint        obs_dout [NI];

  assign obs_dout[0] = longint'($signed(dout0));
  assign obs_dout[1] = longint'($signed(dout1));
  assign obs_dout[2] = longint'($signed(dout2));
  assign obs_dout[3] = longint'($signed(dout3));

  tc_pipe_mul_sat #(.DIN0_WIDTH(18), .DIN1_WIDTH(18), .DOUT_WIDTH(34),
                    .NUM_STAGE(3), .SHIFT(0)) u0 (
    .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .din_valid(din_valid),
    .din0(din0), .din1(din1),
    .dout_valid(vld[0]), .dout(dout0), .ovf(ovf[0]));

  tc_pipe_mul_sat #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(10),
                    .NUM_STAGE(2), .SHIFT(4)) u1 (
    .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .din_valid(din_valid),
    .din0(din0[7:0]), .din1(din1[7:0]),
    .dout_valid(vld[1]), .dout(dout1), .ovf(ovf[1]));

  tc_pipe_mul_sat #(.DIN0_WIDTH(18), .DIN1_WIDTH(18), .DOUT_WIDTH(34),
                    .NUM_STAGE(1), .SHIFT(0)) u2 (
    .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .din_valid(din_valid),
    .din0(din0), .din1(din1),
    .dout_valid(vld[2]), .dout(dout2), .ovf(ovf[2]));

  tc_pipe_mul_sat #(.DIN0_WIDTH(12), .DIN1_WIDTH(10), .DOUT_WIDTH(12),
                    .NUM_STAGE(5), .SHIFT(3)) u3 (
    .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .din_valid(din_valid),
    .din0(din0[11:0]), .din1(din1[9:0]),
    .dout_valid(vld[3]), .dout(dout3), .ovf(ovf[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  bit last_en;

  typedef struct {
    bit     v;
    longint a;
    longint b;
  } ent_t;

  ent_t   hist[$];
  int     n_en;
  bit     exp_vld [NI];
  bit     exp_ovf [NI];
  longint exp_dout [NI];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  task automatic ref_calc(input longint a, input longint b, input int k,
                          output longint d, output bit o);
    longint p, r, hi, lo;
    p = sx(a, P_W0[k]) * sx(b, P_W1[k]);
    if (P_SH[k] > 0) r = (p + (longint'(1) <<< (P_SH[k] - 1))) >>> P_SH[k];
    else             r = p;
    hi = (longint'(1) <<< (P_DW[k] - 1)) - 1;
    lo = -hi - 1;
    o  = (r > hi) || (r < lo);
`ifdef TC_PIPE_MUL_SAT_EN
    d = (r > hi) ? hi : ((r < lo) ? lo : r);
`else
    d = sx(r, P_DW[k]);
`endif
  endtask

  task automatic model_update(input bit rst, input bit c, input bit v,
                              input longint a, input longint b);
    longint d;
    bit     o;
    ent_t   e;
    if (rst) begin
      hist.delete();
      n_en = 0;
      for (int k = 0; k < NI; k++) begin
        exp_vld[k] = 1'b0; exp_ovf[k] = 1'b0; exp_dout[k] = 0;
      end
    end else if (c) begin
      e.v = v; e.a = a; e.b = b;
      hist.push_back(e);
      n_en++;
      if (hist.size() > 8) void'(hist.pop_front());
      for (int k = 0; k < NI; k++) begin
        if (n_en >= P_NS[k] && hist[hist.size() - P_NS[k]].v) begin
          ref_calc(hist[hist.size() - P_NS[k]].a, hist[hist.size() - P_NS[k]].b, k, d, o);
          exp_vld[k] = 1'b1; exp_dout[k] = d; exp_ovf[k] = o;
        end else begin
          exp_vld[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d_vld", k),  longint'(vld[k]), longint'(exp_vld[k]));
      chk($sformatf("u%0d_dout", k), obs_dout[k],      exp_dout[k]);
      chk($sformatf("u%0d_ovf", k),  longint'(ovf[k]), longint'(exp_ovf[k]));
    end
  endtask

  // Inputs change at the falling edge; outputs are compared at the next one.
  task automatic step(input bit rst, input bit c, input bit v,
                      input longint a, input longint b);
    ap_rst = rst; ce = c; din_valid = v;
    din0 = a[17:0]; din1 = b[17:0];
    @(posedge clk);
    model_update(rst, c, v, a, b);
    last_en = c && !rst;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  longint got[$];
  longint big;

  initial begin
    ap_rst = 1'b1; ce = 1'b0; din_valid = 1'b0; din0 = '0; din1 = '0;
    n_en = 0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 5, 5);

    // single product, latency 3 on the default build
    step(1'b0, 1'b1, 1'b1, 1000, -3);
    chk("lat_early1", longint'(vld[0]), 0);
    idle(1);
    chk("lat_early2", longint'(vld[0]), 0);
    idle(1);
    chk("lat_vld", longint'(vld[0]), 1);
    chk("lat_dout", obs_dout[0], -3000);
    chk("lat_ovf", longint'(ovf[0]), 0);
    idle(1);
    chk("lat_vld_drop", longint'(vld[0]), 0);
    chk("lat_hold", obs_dout[0], -3000);

    // most negative squared
    step(1'b0, 1'b1, 1'b1, -131072, -131072);
    idle(2);
`ifdef TC_PIPE_MUL_SAT_EN
    big = 64'sd8589934591;
`else
    big = 0;
`endif
    chk("minsq_dout", obs_dout[0], big);
    chk("minsq_ovf", longint'(ovf[0]), 1);
    idle(2);

    // rounding shift on u1
    step(1'b0, 1'b1, 1'b1, 7, 5);
    step(1'b0, 1'b1, 1'b1, -7, 5);
    chk("rnd_p", obs_dout[1], 2);
    chk("rnd_p_ovf", longint'(ovf[1]), 0);
    step(1'b0, 1'b1, 1'b1, 8, 1);
    chk("rnd_n", obs_dout[1], -2);
    chk("rnd_n_ovf", longint'(ovf[1]), 0);
    idle(1);
    chk("rnd_half", obs_dout[1], 1);
    chk("rnd_half_ovf", longint'(ovf[1]), 0);
    idle(4);

    // stream with a two-cycle stall after the third pair
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        step(1'b0, 1'b0, 1'b1, 99, 99);
        step(1'b0, 1'b0, 1'b1, 99, 99);
      end
      step(1'b0, 1'b1, 1'b1, i, i + 1);
      if (last_en && vld[0]) got.push_back(obs_dout[0]);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 0, 0);
      if (last_en && vld[0]) got.push_back(obs_dout[0]);
    end
    chk("stream_cnt", longint'(got.size()), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("stream_%0d", i), (i < got.size()) ? got[i] : -1, i * (i + 1));
    end

    // reset while two pairs are in flight
    step(1'b0, 1'b1, 1'b1, 5, 6);
    step(1'b0, 1'b1, 1'b1, 7, 8);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("flush_vld", longint'(vld[0]), 0);
      chk("flush_dout", obs_dout[0], 0);
      chk("flush_ovf", longint'(ovf[0]), 0);
    end
    step(1'b0, 1'b1, 1'b1, 9, 10);
    idle(2);
    chk("flush_new_vld", longint'(vld[0]), 1);
    chk("flush_new_dout", obs_dout[0], 90);

    // one-stage instance, back-to-back
    step(1'b0, 1'b1, 1'b1, 3, 4);
    chk("n1_a_vld", longint'(vld[2]), 1);
    chk("n1_a_dout", obs_dout[2], 12);
    step(1'b0, 1'b1, 1'b1, -5, 6);
    chk("n1_b_vld", longint'(vld[2]), 1);
    chk("n1_b_dout", obs_dout[2], -30);
    idle(6);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      longint a, b;
      bit r, c, v;
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 9) < 7);
      a = sx(longint'($urandom_range(0, 262143)), 18);
      b = sx(longint'($urandom_range(0, 262143)), 18);
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1) ? -131072 : 131071;
      if ($urandom_range(0, 7) == 0) b = $urandom_range(0, 1) ? -131072 : 131071;
      step(r, c, v, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
